// File: rtl/spi_rx_fifo.sv
// Receive FIFO behind spi_master: captures single-cycle word strobes and presents them
// first-word-fall-through on a valid/ready port. Words arriving while full are dropped.
module spi_rx_fifo #(
  parameter int unsigned K_WIDTH = 16,
  parameter int unsigned K_DEPTH = 8,
  parameter int unsigned K_AFULL = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [K_WIDTH-1:0]         i_data,
  input  logic                       i_valid,
  input  logic                       i_flush,
  input  logic                       i_clr_ovf,
  output logic [K_WIDTH-1:0]         o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(K_DEPTH):0]   o_level,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_afull,
  output logic                       o_overflow
);

  localparam int unsigned AW = $clog2(K_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthLvl = LW'(K_DEPTH);
  localparam logic [LW-1:0] AfullLvl = LW'(K_AFULL);

  logic [K_WIDTH-1:0] mem_q [K_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;

  logic empty, full;
  logic push, pop, drop;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == DepthLvl);
    // Flush overrides both sides of the handshake; a full FIFO still accepts when it pops.
    pop   = !i_flush && !empty && i_ready;
    push  = !i_flush && i_valid && (!full || pop);
    drop  = !i_flush && i_valid && full && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(K_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data     = mem_q[rd_ptr_q];
  assign o_valid    = !empty;
  assign o_level    = level_q;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_afull    = (level_q >= AfullLvl);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Self-checking bench for spi_rx_fifo: directed scenarios plus a randomized run compared
// against a queue-based reference model.
module tb_spi_rx_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_clr_ovf = 1'b0;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic [3:0]    o_level;
  logic          o_empty;
  logic          o_full;
  logic          o_afull;
  logic          o_overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of stored words plus the sticky flag.
  logic [W-1:0] q[$];
  bit           m_ovf = 1'b0;

  spi_rx_fifo #(.K_WIDTH(W), .K_DEPTH(DEPTH), .K_AFULL(AFULL)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_flush    (i_flush),
    .i_clr_ovf  (i_clr_ovf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_afull    (o_afull),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Apply one cycle of inputs, advance the model, and return 1 time unit after the edge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f,
                       input bit c);
    int sz;
    bit mpop;
    bit mdrop;
    i_valid = v; i_data = d; i_ready = r; i_flush = f; i_clr_ovf = c;
    sz    = q.size();
    mpop  = (sz > 0) && r;
    mdrop = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (mpop) void'(q.pop_front());
      if (v) begin
        if (sz < DEPTH || mpop) q.push_back(d);
        else mdrop = 1'b1;
      end
    end
    if (mdrop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_data !== 16'h0 || o_level !== 4'd0 || o_full !== 1'b0 || o_afull !== 1'b0 ||
        o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: data=%h level=%0d full=%b afull=%b ovf=%b, want 0/0/0/0/0",
               o_data, o_level, o_full, o_afull, o_overflow);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_empty !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: empty=%b valid=%b, want 1/0", i, o_empty, o_valid);
      end
    end
  endtask

  task automatic test_order();
    logic [W-1:0] words [3];
    words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001;
    for (int i = 0; i < 3; i++) drive(1'b1, words[i], 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_level !== 4'd3) begin
      errors++;
      $display("FAIL order_level: got %0d want 3", o_level);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== words[i]) begin
        errors++;
        $display("FAIL order_data[%0d]: valid=%b data=%h want 1/%h", i, o_valid, o_data, words[i]);
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (o_empty !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_empty: empty=%b valid=%b want 1/0", o_empty, o_valid);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_afull !== (i + 1 >= AFULL) || o_full !== (i + 1 == DEPTH)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: afull=%b full=%b want %b/%b", i + 1, o_afull, o_full,
                 (i + 1 >= AFULL), (i + 1 == DEPTH));
      end
    end
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_overflow !== 1'b1 || o_level !== 4'd8) begin
      errors++;
      $display("FAIL fill_drop: ovf=%b level=%0d want 1/8", o_overflow, o_level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (o_data !== W'(i)) begin
        errors++;
        $display("FAIL fill_drain[%0d]: got %h want %h", i, o_data, W'(i));
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_empty: empty=%b want 1", o_empty);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_clr: ovf=%b want 0", o_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] last;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_level !== 4'd8 || o_overflow !== 1'b0 || o_data !== 16'h0001) begin
      errors++;
      $display("FAIL fullpp: level=%0d ovf=%b head=%h want 8/0/0001", o_level, o_overflow, o_data);
    end
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = o_data;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (last !== 16'h0100 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL fullpp_last: last=%h empty=%b want 0100/1", last, o_empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h0A00 + W'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_level !== 4'd0 || o_empty !== 1'b1 || o_overflow !== m_ovf) begin
      errors++;
      $display("FAIL flush: level=%0d empty=%b ovf=%b want 0/1/%b", o_level, o_empty, o_overflow,
               m_ovf);
    end
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_data !== 16'h7777 || o_level !== 4'd1) begin
      errors++;
      $display("FAIL flush_next: data=%h level=%0d want 7777/1", o_data, o_level);
    end
    for (int i = 1; i < DEPTH; i++) drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_vs_clr: ovf=%b want 1", o_overflow);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_overflow !== 1'b1 || o_level !== 4'd0) begin
      errors++;
      $display("FAIL flush_keeps_ovf: ovf=%b level=%0d want 1/0", o_overflow, o_level);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      drive(($urandom_range(0, 9) < 6), W'($urandom), ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
      checks++;
      if (o_level !== 4'(q.size()) || o_valid !== (q.size() > 0) ||
          o_full !== (q.size() == DEPTH) || o_afull !== (q.size() >= AFULL) ||
          o_overflow !== m_ovf || (q.size() > 0 && o_data !== q[0])) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: level=%0d valid=%b data=%h ovf=%b want level=%0d ovf=%b head=%h",
                   n, o_level, o_valid, o_data, o_overflow, q.size(), m_ovf,
                   (q.size() > 0) ? q[0] : 16'h0);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'hC000 + W'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_level !== 4'd4) begin
      errors++;
      $display("FAIL midrst_level: got %0d want 4", o_level);
    end
    #2;
    i_rstn = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    checks++;
    if (o_level !== 4'd0 || o_valid !== 1'b0 || o_empty !== 1'b1 || o_data !== 16'h0 ||
        o_full !== 1'b0 || o_afull !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: level=%0d valid=%b empty=%b data=%h ovf=%b want 0/0/1/0000/0",
               o_level, o_valid, o_empty, o_data, o_overflow);
    end
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    drive(1'b1, 16'h4242, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_data !== 16'h4242 || o_level !== 4'd1) begin
      errors++;
      $display("FAIL midrst_resume: data=%h level=%0d want 4242/1", o_data, o_level);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill_overflow();
    test_full_push_pop();
    test_flush();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
